// File: rtl/calc_mon_pkg.sv
// calc_mon_pkg: shared state enum, response codes and default parameters for the response monitor.
package calc_mon_pkg;
  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_CMD_W = 4;
  localparam int DEF_RESP_W = 2;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W = 16;
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;
  localparam logic [1:0] RESP_ILLEGAL = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_WAIT} port_state_t;
endpackage

// File: rtl/calc_resp_monitor_if.sv
// calc_resp_monitor_if: monitored request/response bus plus monitor results.
interface calc_resp_monitor_if import calc_mon_pkg::*; #(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int CMD_W = DEF_CMD_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic [NUM_PORTS*CMD_W-1:0] req_cmd_in;
  logic [NUM_PORTS*32-1:0] req_data_in;
  logic [NUM_PORTS*RESP_W-1:0] out_resp;
  logic [NUM_PORTS*32-1:0] out_data;
  logic [NUM_PORTS-1:0] err_timeout;
  logic [NUM_PORTS-1:0] err_unexp;
  logic [NUM_PORTS-1:0] err_overlap;
  logic [NUM_PORTS-1:0] err_badresp;
  logic [NUM_PORTS*CNT_W-1:0] txn_count;
  logic [NUM_PORTS*CNT_W-1:0] last_lat;
  logic [NUM_PORTS*CNT_W-1:0] max_lat;
  logic err_any;
  modport master (
    output req_cmd_in, req_data_in, out_resp, out_data,
    input err_timeout, err_unexp, err_overlap, err_badresp, txn_count, last_lat, max_lat, err_any
  );
  modport slave (
    input req_cmd_in, req_data_in, out_resp, out_data,
    output err_timeout, err_unexp, err_overlap, err_badresp, txn_count, last_lat, max_lat, err_any
  );
endinterface

// File: rtl/calc_port_mon.sv
// calc_port_mon: protocol checker and latency/transaction statistics for one port.
// CALC_MON_MAXLAT_EN enables the max-latency register; otherwise max_lat is tied to zero.
module calc_port_mon import calc_mon_pkg::*; #(
  parameter int CMD_W = DEF_CMD_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic c_clk,
  input logic reset,
  input logic [CMD_W-1:0] cmd,
  input logic [RESP_W-1:0] resp,
  output logic err_timeout,
  output logic err_unexp,
  output logic err_overlap,
  output logic err_badresp,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_lat
);
  port_state_t state, state_nxt;
  logic [CNT_W-1:0] lat, lat_done;
  logic cmd_v, resp_v, done, tmo, unexp, ovl;
  assign cmd_v = |cmd;
  assign resp_v = resp != RESP_W'(RESP_NONE);
  assign lat_done = lat + 1'b1;
  always_ff @(posedge c_clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_nxt;
  // A response and a new command in the same WAIT cycle chain straight into the next OP2.
  always_comb begin
    state_nxt = state;
    done = 1'b0;
    tmo = 1'b0;
    unexp = 1'b0;
    ovl = 1'b0;
    case (state)
      ST_IDLE: begin
        unexp = resp_v;
        state_nxt = cmd_v ? ST_OP2 : ST_IDLE;
      end
      ST_OP2: begin
        unexp = resp_v;
        ovl = cmd_v;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        done = resp_v;
        tmo = !resp_v && lat == CNT_W'(TIMEOUT - 1);
        ovl = cmd_v && !resp_v;
        state_nxt = resp_v ? (cmd_v ? ST_OP2 : ST_IDLE) : (tmo ? ST_IDLE : ST_WAIT);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge c_clk or negedge reset)
    if (!reset) begin
      lat <= '0;
      txn_count <= '0;
      last_lat <= '0;
      err_timeout <= 1'b0;
      err_unexp <= 1'b0;
      err_overlap <= 1'b0;
      err_badresp <= 1'b0;
    end else begin
      lat <= state == ST_WAIT ? lat_done : '0;
      if (done) begin
        txn_count <= &txn_count ? txn_count : txn_count + 1'b1;
        last_lat <= lat_done;
      end
      err_timeout <= err_timeout | tmo;
      err_unexp <= err_unexp | unexp;
      err_overlap <= err_overlap | ovl;
      err_badresp <= err_badresp | (resp == RESP_W'(RESP_ILLEGAL));
    end
`ifdef CALC_MON_MAXLAT_EN
  always_ff @(posedge c_clk or negedge reset)
    if (!reset) max_lat <= '0;
    else if (done && lat_done > max_lat) max_lat <= lat_done;
`else
  assign max_lat = '0;
`endif
endmodule

// File: rtl/calc_resp_monitor.sv
// calc_resp_monitor: NUM_PORTS independent request/response monitors with a registered error summary.
// CALC_MON_MAXLAT_EN enables per-port max-latency tracking.
module calc_resp_monitor import calc_mon_pkg::*; #(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int CMD_W = DEF_CMD_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic c_clk,
  input logic reset,
  calc_resp_monitor_if.slave bus
);
  logic [NUM_PORTS-1:0] tmo, unexp, ovl, bad;
  logic [NUM_PORTS*CNT_W-1:0] txn, last, maxl;
  logic err_any_q;
  logic unused_data;
  // Operand and result data are carried on the bus but not inspected by the monitor.
  assign unused_data = ^{bus.req_data_in, bus.out_data};
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc_port_mon #(.CMD_W(CMD_W), .RESP_W(RESP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_mon (
      .c_clk(c_clk),
      .reset(reset),
      .cmd(bus.req_cmd_in[g*CMD_W +: CMD_W]),
      .resp(bus.out_resp[g*RESP_W +: RESP_W]),
      .err_timeout(tmo[g]),
      .err_unexp(unexp[g]),
      .err_overlap(ovl[g]),
      .err_badresp(bad[g]),
      .txn_count(txn[g*CNT_W +: CNT_W]),
      .last_lat(last[g*CNT_W +: CNT_W]),
      .max_lat(maxl[g*CNT_W +: CNT_W])
    );
  end
  always_ff @(posedge c_clk or negedge reset)
    if (!reset) err_any_q <= 1'b0;
    else err_any_q <= |{tmo, unexp, ovl, bad};
  assign bus.err_timeout = tmo;
  assign bus.err_unexp = unexp;
  assign bus.err_overlap = ovl;
  assign bus.err_badresp = bad;
  assign bus.txn_count = txn;
  assign bus.last_lat = last;
  assign bus.max_lat = maxl;
  assign bus.err_any = err_any_q;
endmodule

// File: doc/calc_resp_monitor.md
CALC_RESP_MONITOR -- requirements
Module: calc_resp_monitor

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of independent request/response ports monitored.
REQ-002 Parameter CMD_W, default 4, command field width per port.
REQ-003 Parameter RESP_W, default 2, response field width per port.
REQ-004 Parameter TIMEOUT, default 16, max cycles from operand-2 to response before timeout.
REQ-005 Parameter CNT_W, default 16, width of per-port transaction and latency counters.
REQ-006 c_clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req_cmd_in  input  NUM_PORTS*CMD_W  per-port command, port p at bits [p*CMD_W +: CMD_W]; nonzero starts a transaction.
REQ-009 req_data_in  input  NUM_PORTS*32  per-port operand data, operand 1 with command, operand 2 next cycle.
REQ-010 out_resp  input  NUM_PORTS*RESP_W  per-port response code, nonzero for exactly one cycle per response.
REQ-011 out_data  input  NUM_PORTS*32  per-port result data, valid with out_resp.
REQ-012 err_timeout  output  NUM_PORTS  sticky flag, no response within TIMEOUT.
REQ-013 err_unexp  output  NUM_PORTS  sticky flag, response with no outstanding transaction.
REQ-014 err_overlap  output  NUM_PORTS  sticky flag, new command while one is outstanding.
REQ-015 err_badresp  output  NUM_PORTS  sticky flag, response code 2'b00 never valid as response, 2'b11 is illegal.
REQ-016 txn_count  output  NUM_PORTS*CNT_W  completed transactions per port, saturating.
REQ-017 last_lat  output  NUM_PORTS*CNT_W  latency (cycles) of the most recent completed transaction.
REQ-018 max_lat  output  NUM_PORTS*CNT_W  largest latency observed per port (see Configuration).
REQ-019 err_any  output  1  OR of all error flags, registered.

Function
REQ-020 Each port SHALL run an FSM: IDLE -> OP2 (on nonzero cmd) -> WAIT (next cycle, unconditional) -> IDLE (on nonzero resp).
REQ-021 Latency counter SHALL clear entering WAIT and increment each WAIT cycle; latency reported = counter value +1 at the response cycle (response on first WAIT cycle = latency 1).
REQ-022 On response in WAIT: txn_count +1 (saturate at all-ones), last_lat updated same edge, FSM -> IDLE.
REQ-023 Counter reaching TIMEOUT in WAIT without response SHALL set err_timeout and return FSM to IDLE; no txn_count increment.
REQ-024 Nonzero resp in IDLE or OP2 SHALL set err_unexp; FSM unchanged.
REQ-025 Nonzero cmd in OP2 or WAIT SHALL set err_overlap; command ignored, FSM unchanged.
REQ-026 Response and new nonzero cmd in same WAIT cycle SHALL complete the current transaction and start the new one (FSM -> OP2), no error.
REQ-027 Response with code 2'b11 SHALL set err_badresp in addition to normal completion.
REQ-028 All error flags SHALL be sticky until reset; err_any lags flags by one cycle.
REQ-029 Ports SHALL be fully independent; simultaneous events on different ports SHALL not interact.

Reset
REQ-030 Reset low SHALL immediately force all FSMs to IDLE and all outputs, counters and flags to zero.
REQ-031 Reset asserted mid-transaction SHALL discard it with no error or count; first rising edge after deassertion samples normally.

Configuration
REQ-032 Macro CALC_MON_MAXLAT_EN defined: max_lat SHALL update to last latency when greater than stored value.
REQ-033 Macro CALC_MON_MAXLAT_EN undefined: max_lat port SHALL remain present, tied to zero, no max registers synthesised.

Structure
REQ-034 Package calc_mon_pkg SHALL hold the port FSM state enum, response code constants (NONE=0, OK=1, ERR=2, ILLEGAL=3) and default parameter values.
REQ-035 Sub-module calc_port_mon SHALL implement one port; top SHALL instantiate NUM_PORTS copies via generate and OR-reduce errors.

Verification
REQ-036 Port 0 cmd=1 then response 2'b01 three cycles after OP2 -> txn_count[0]=1, last_lat[0]=3, no errors.
REQ-037 Port 2 cmd=2, no response for 16 WAIT cycles -> err_timeout[2]=1, err_any=1 next cycle, txn_count[2]=0.
REQ-038 Port 1 out_resp=2'b01 while IDLE -> err_unexp[1]=1; port 1 cmd during WAIT -> err_overlap[1]=1.
REQ-039 All 4 ports issue cmds same cycle, responses at latencies 1,2,3,4 -> txn_count all 1, last_lat 1,2,3,4; with CALC_MON_MAXLAT_EN max_lat equals last_lat, without it max_lat all 0.
REQ-040 Reset low during port 3 WAIT -> all outputs 0 asynchronously; later response on port 3 -> err_unexp[3]=1.
